sb_ram40_4k: RTL and testbench
==============================

Name: sb_ram40_4k

Overview:
- Synchronous 4096-bit block RAM with one write port and one read port.
- Used by the flanger as its 256-entry x 16-bit circular delay line: the write address increments every sample, and the read tap trails it by a modulated offset.
- Read and write widths are configurable to 256x16, 512x8, 1024x4 or 2048x2.
- Reads are registered with one cycle of latency.

Parameters:
- WRITE_MODE, 0: write geometry. 0=256x16, 1=512x8, 2=1024x4, 3=2048x2.
- READ_MODE, 0: read geometry, same encoding as WRITE_MODE.

Ports:
- sample_clk  in  1  single clock for both ports; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears the read register only.
- RADDR  in  11  read address; only the low 8/9/10/11 bits are used for READ_MODE 0/1/2/3; upper bits are ignored.
- RE  in  1  read enable.
- RCLKE  in  1  read clock enable; the read port is frozen when low.
- RDATA  out  16  registered read data.
- WADDR  in  11  write address; only the low 8/9/10/11 bits are used for WRITE_MODE 0/1/2/3.
- WDATA  in  16  write data.
- WE  in  1  write enable.
- WCLKE  in  1  write clock enable.
- MASK  in  16  per-bit write mask, used in WRITE_MODE 0 only; 1 = bit not written.

Behaviour:
- Storage is a linear array of 4096 bits, index 0..4095.
  - A word of width W at address A occupies bits A*W .. A*W+W-1.
  - Mixed read/write modes address the same bits consistently.
- Memory contents initialise to all zeros at time 0. Reset does not alter them.
- Write: at a rising edge with WE=1 and WCLKE=1, the word at WADDR takes WDATA.
  - Narrow modes use WDATA[W-1:0]; higher WDATA bits are ignored.
  - In mode 0, bits where MASK[i]=1 keep their old value. MASK is ignored in modes 1-3.
- Read: at a rising edge with RE=1 and RCLKE=1, RDATA takes the word at RADDR.
  - The data appears after that edge, i.e. 1-cycle latency.
  - Narrow modes place the word in RDATA[W-1:0] and drive RDATA[15:W]=0.
- When RE=0 or RCLKE=0, RDATA holds its previous value.
- Read-during-write to the same location on the same edge returns the OLD contents (read-before-write). The new value is visible on the next read.
- Reset: at a rising edge with reset=1, RDATA <= 0.
  - Reset has priority over a read on that edge.
  - A write on the same edge still completes.
  - Reset mid-stream does not disturb stored data.
- Address wrap: upper unused address bits are ignored, so in mode 0 address 256 aliases address 0. The delay line relies on 8-bit natural wrap.
- No X propagation for in-range inputs. RDATA is 0 after reset and before any read.
- Data is treated as unsigned bits; sign handling belongs to the user (the flanger stores signed 12-bit samples sign-extended into 16 bits).

Test Plan:
- Mode 0/0, reset then write WADDR=0x05 WDATA=0xBEEF, next cycle RE=1 RADDR=0x05 -> RDATA=0xBEEF exactly one edge later; RDATA=0x0000 before that.
- Mode 0/0, circular delay: write 0,1,2,... at WADDR incrementing 0..255 then wrapping, read RADDR=WADDR-10 each cycle -> RDATA equals the value written 11 edges earlier (10 offset + 1 latency). Confirm wrap at 255->0.
- Same-address read/write: location 0x20 holds 0x1111, write 0x2222 while reading 0x20 -> RDATA=0x1111; the next read gives 0x2222.
- MASK: location 0x00 holds 0xFFFF, write 0x0000 with MASK=0xFF00 -> read returns 0xFF00. MASK in mode 1 has no effect.
- Mode 1/0: write bytes 0x34 at addr 0 and 0x12 at addr 1 (WRITE_MODE=1, READ_MODE=0), read addr 0 -> 0x1234. Mode 3 reads of 2-bit words return 0 in RDATA[15:2].
- Control: RE=0 or RCLKE=0 holds RDATA across address changes. WE=1 with WCLKE=0 does not write. reset=1 forces RDATA=0 while memory retains 0xBEEF, re-read after reset -> 0xBEEF.

Source files
------------

// File: rtl/sb_ram40_4k.sv
// sb_ram40_4k: 4096-bit single-clock block RAM with configurable read/write geometry
module sb_ram40_4k #(
    parameter int WRITE_MODE = 0,
    parameter int READ_MODE  = 0
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic [10:0] RADDR,
    input  logic        RE,
    input  logic        RCLKE,
    output logic [15:0] RDATA,
    input  logic [10:0] WADDR,
    input  logic [15:0] WDATA,
    input  logic        WE,
    input  logic        WCLKE,
    input  logic [15:0] MASK
);
    localparam int WW = 16 >> WRITE_MODE;
    localparam int RW = 16 >> READ_MODE;
    localparam logic [15:0] WMSK = 16'((32'd1 << WW) - 32'd1);
    localparam logic [15:0] RMSK = 16'((32'd1 << RW) - 32'd1);
    logic [15:0] mem_q [256] = '{default: 16'h0000};
    logic [15:0] rdata_q, rdata_d, wen, wdat;
    logic [7:0]  widx, ridx;
    logic [3:0]  woff, roff;
    // A narrow word lives in 16-bit row addr>>mode at bit offset (addr low bits)*width
    always_comb begin
        widx    = 8'(WADDR >> WRITE_MODE);
        ridx    = 8'(RADDR >> READ_MODE);
        woff    = 4'((WADDR[3:0] & 4'((1 << WRITE_MODE) - 1)) << (4 - WRITE_MODE));
        roff    = 4'((RADDR[3:0] & 4'((1 << READ_MODE) - 1)) << (4 - READ_MODE));
        wen     = (WRITE_MODE == 0 ? ~MASK : WMSK) << woff;
        wdat    = (WDATA & WMSK) << woff;
        rdata_d = (RE && RCLKE) ? ((mem_q[ridx] >> roff) & RMSK) : rdata_q;
    end
    // Write port merges new bits into the row; memory is never reset
    always_ff @(posedge sample_clk) begin
        if (WE && WCLKE) mem_q[widx] <= (mem_q[widx] & ~wen) | (wdat & wen);
    end
    // Read register samples the pre-write row contents; reset wins over a read
    always_ff @(posedge sample_clk) begin
        rdata_q <= reset ? 16'h0000 : rdata_d;
    end
    assign RDATA = rdata_q;
endmodule

// File: tb/tb_sb_ram40_4k.sv
// tb_sb_ram40_4k: scoreboard bench driving four geometry variants of the RAM
module tb_sb_ram40_4k;
    logic        clk = 1'b0;
    logic        rst, re, rclke, wclke, we;
    logic [1:0]  sel;
    logic [10:0] raddr, waddr;
    logic [15:0] wdata, mask;
    logic [3:0]  we_v;
    logic [15:0] rdata [4];
    int          cyc = 0;
    int          vectors = 0;
    int          errs = 0;

    typedef struct {
        int          at;
        int          inst;
        logic [15:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    assign we_v = we ? 4'(4'd1 << sel) : 4'd0;

    sb_ram40_4k #(.WRITE_MODE(0), .READ_MODE(0)) u0 (.sample_clk(clk), .reset(rst), .RADDR(raddr), .RE(re), .RCLKE(rclke), .RDATA(rdata[0]), .WADDR(waddr), .WDATA(wdata), .WE(we_v[0]), .WCLKE(wclke), .MASK(mask));
    sb_ram40_4k #(.WRITE_MODE(1), .READ_MODE(0)) u1 (.sample_clk(clk), .reset(rst), .RADDR(raddr), .RE(re), .RCLKE(rclke), .RDATA(rdata[1]), .WADDR(waddr), .WDATA(wdata), .WE(we_v[1]), .WCLKE(wclke), .MASK(mask));
    sb_ram40_4k #(.WRITE_MODE(3), .READ_MODE(3)) u2 (.sample_clk(clk), .reset(rst), .RADDR(raddr), .RE(re), .RCLKE(rclke), .RDATA(rdata[2]), .WADDR(waddr), .WDATA(wdata), .WE(we_v[2]), .WCLKE(wclke), .MASK(mask));
    sb_ram40_4k #(.WRITE_MODE(0), .READ_MODE(3)) u3 (.sample_clk(clk), .reset(rst), .RADDR(raddr), .RE(re), .RCLKE(rclke), .RDATA(rdata[3]), .WADDR(waddr), .WDATA(wdata), .WE(we_v[3]), .WCLKE(wclke), .MASK(mask));

    // Monitor: after each rising edge, compare every expectation due on that edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (rdata[e.inst] !== e.exp) begin
                    errs++;
                    $display("FAIL %s (u%0d): RDATA=%h expected %h", e.name, e.inst, rdata[e.inst], e.exp);
                end
            end
        end
    end

    // Expect a RDATA value right after the coming rising edge
    task automatic expect_rd(input int inst, input logic [15:0] exp, input string name);
        sb.push_back('{cyc + 1, inst, exp, name});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; re = 0; rclke = 1; wclke = 1; we = 0; mask = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] s, input logic [10:0] a, input logic [15:0] d);
        sel = s; we = 1; waddr = a; wdata = d;
    endtask

    task automatic rd(input logic [10:0] a);
        re = 1; raddr = a;
    endtask

    initial begin
        idle();
        sel = 0; raddr = 0; waddr = 0; wdata = 0;
        rst = 1;
        tick();
        for (int i = 0; i < 4; i++) expect_rd(i, 16'h0000, "reset_clear");
        tick();
        idle(); wr(0, 11'h005, 16'hBEEF);
        expect_rd(0, 16'h0000, "zero_before_read");
        tick();
        idle(); rd(11'h005);
        expect_rd(0, 16'hBEEF, "basic_read");
        tick();
        idle(); raddr = 11'h007;
        expect_rd(0, 16'hBEEF, "hold_re0");
        tick();
        idle(); rd(11'h007); rclke = 0;
        expect_rd(0, 16'hBEEF, "hold_rclke0");
        tick();
        idle(); wr(0, 11'h005, 16'h0000); wclke = 0;
        tick();
        idle(); rd(11'h005);
        expect_rd(0, 16'hBEEF, "wclke0_no_write");
        tick();
        idle(); rd(11'h005); rst = 1;
        expect_rd(0, 16'h0000, "reset_over_read");
        tick();
        idle(); rd(11'h005);
        expect_rd(0, 16'hBEEF, "reread_after_reset");
        tick();
        idle(); wr(0, 11'h020, 16'h1111);
        tick();
        idle(); wr(0, 11'h020, 16'h2222); rd(11'h020);
        expect_rd(0, 16'h1111, "read_before_write");
        tick();
        idle(); rd(11'h020);
        expect_rd(0, 16'h2222, "new_value_visible");
        tick();
        idle(); wr(0, 11'h000, 16'hFFFF);
        tick();
        idle(); wr(0, 11'h000, 16'h0000); mask = 16'hFF00;
        tick();
        idle(); rd(11'h000);
        expect_rd(0, 16'hFF00, "mask_mode0");
        tick();
        idle(); rd(11'h105);
        expect_rd(0, 16'hBEEF, "addr_alias_256");
        tick();
        for (int k = 0; k < 300; k++) begin
            idle(); wr(0, 11'(k % 256), 16'(k)); rd(11'((k - 10) & 255));
            if (k >= 10) expect_rd(0, 16'(k - 10), "circular_delay");
            tick();
        end
        idle(); wr(1, 11'h000, 16'hAB34); mask = 16'hFFFF;
        tick();
        idle(); wr(1, 11'h001, 16'hCD12); mask = 16'hFFFF;
        tick();
        idle(); rd(11'h000);
        expect_rd(1, 16'h1234, "mode1_write_mode0_read");
        tick();
        idle(); wr(2, 11'h005, 16'hFFFF);
        tick();
        idle(); wr(2, 11'h7FF, 16'h0002); rd(11'h005);
        expect_rd(2, 16'h0003, "mode3_upper_zero");
        tick();
        idle(); rd(11'h004);
        expect_rd(2, 16'h0000, "mode3_neighbour");
        tick();
        idle(); rd(11'h7FF);
        expect_rd(2, 16'h0002, "mode3_top_addr");
        tick();
        idle(); wr(3, 11'h000, 16'hBEEF);
        tick();
        idle(); wr(3, 11'h001, 16'h0001);
        tick();
        begin
            logic [15:0] m3 [8];
            m3 = '{16'd3, 16'd3, 16'd2, 16'd3, 16'd2, 16'd3, 16'd3, 16'd2};
            for (int a = 0; a < 8; a++) begin
                idle(); rd(11'(a));
                expect_rd(3, m3[a], "mode0_write_mode3_read");
                tick();
            end
        end
        idle(); rd(11'h008);
        expect_rd(3, 16'h0001, "mode3_second_row");
        tick();
        idle();
        repeat (3) tick();
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
